frame_memory_arbiter: RTL and testbench

Shares one single-port synchronous frame SRAM (96-bit words, 512×512/4 deep) between the frame write path and the display read path. Reads take priority because the display scan cannot wait. Writes are absorbed in a small FIFO and drained into idle memory cycles. A burst limit guarantees that writes make progress during long read runs. The block sits between the memory write/read control blocks and the SRAM macro.

---
 rtl/frame_memory_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_frame_memory_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_memory_arbiter.sv
// -----------------------------------------------------------------------------
// frame_memory_arbiter
//
// Shares one single-port synchronous frame SRAM between the frame write path
// and the display read path. Reads win every cycle they are offered, because
// the display scan cannot wait. Writes are absorbed in a small FIFO and drained
// into cycles that carry no read. A read-burst limit forces one write slot
// after MAX_RD_BURST consecutive reads whenever a write is waiting.
//
// Optional feature macro: FRAME_MEM_ARB_STAT_EN
//   defined   -> o_wstall_cnt counts cycles with i_wreq & !o_wready
//                (saturating at 32'hFFFF_FFFF)
//   undefined -> o_wstall_cnt is tied to 0 and no counter is built
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   i_wreq/o_wready    write request / accept, with i_waddr, i_wdata
//   i_rreq/o_rready    read request / accept, with i_raddr
//   o_rvalid/o_rdata   read return, two cycles after acceptance
//   o_mem_*            registered SRAM controls (cs, we, addr, wdata)
//   i_mem_rdata        SRAM read data, valid the cycle after the read sample
//   o_wfifo_level      write FIFO occupancy
//   o_wstall_cnt       write back-pressure cycle count
//
// Handshake: a transfer happens on a rising edge where request and ready are
// both 1. Ready never depends on the request in the same cycle; a request may
// be raised or dropped freely while ready is low.
// -----------------------------------------------------------------------------
module frame_memory_arbiter #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_DEPTH   = 512*512/4,
  parameter int ADDR_WIDTH   = $clog2(ADDR_DEPTH),
  parameter int WFIFO_DEPTH  = 4,
  parameter int MAX_RD_BURST = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_wreq,
  output logic                           o_wready,
  input  logic [ADDR_WIDTH-1:0]          i_waddr,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic                           i_rreq,
  output logic                           o_rready,
  input  logic [ADDR_WIDTH-1:0]          i_raddr,
  output logic                           o_rvalid,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic                           o_mem_cs,
  output logic                           o_mem_we,
  output logic [ADDR_WIDTH-1:0]          o_mem_addr,
  output logic [DATA_WIDTH-1:0]          o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]          i_mem_rdata,
  output logic [$clog2(WFIFO_DEPTH):0]   o_wfifo_level,
  output logic [31:0]                    o_wstall_cnt
);

  localparam int PTR_W   = $clog2(WFIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int BURST_W = $clog2(MAX_RD_BURST + 1);
  localparam int ENT_W   = ADDR_WIDTH + DATA_WIDTH;

  // FIFO storage is not reset: pointers and level define what is valid.
  logic [ENT_W-1:0] fifo_mem_q [WFIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [BURST_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic                  run_q, run_d;        // 0 while in reset
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rd_v1_q, rd_v1_d;    // read presented to SRAM
  logic                  rd_v2_q, rd_v2_d;    // SRAM data on i_mem_rdata
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             force_wr;
  logic             rd_acc;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  assign fifo_full  = (level_q == LVL_W'(WFIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  // A write has waited through a full read burst: steal exactly one slot.
  assign force_wr   = (burst_cnt_q == BURST_W'(MAX_RD_BURST)) && !fifo_empty;
  assign o_wready   = run_q && !fifo_full;
  assign o_rready   = run_q && !force_wr;
  assign rd_acc     = i_rreq && o_rready;
  // Push is judged on the registered level only, so a full FIFO refuses a
  // push even when a pop happens in the same cycle.
  assign push       = i_wreq && o_wready;
  assign pop        = !rd_acc && !fifo_empty;
  assign head       = fifo_mem_q[rd_ptr_q];

  always_comb begin
    run_d       = 1'b1;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    burst_cnt_d = '0;
    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (rd_acc) begin
      mem_cs_d   = 1'b1;
      mem_addr_d = i_raddr;
      // Saturation is reachable only with an empty FIFO (else force_wr).
      if (burst_cnt_q == BURST_W'(MAX_RD_BURST)) burst_cnt_d = burst_cnt_q;
      else                                       burst_cnt_d = burst_cnt_q + BURST_W'(1);
    end else if (pop) begin
      mem_cs_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = head[ENT_W-1:DATA_WIDTH];
      mem_wdata_d = head[DATA_WIDTH-1:0];
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push && pop) level_d = level_q - LVL_W'(1);

    rd_v1_d  = rd_acc;
    rd_v2_d  = rd_v1_q;
    rvalid_d = rd_v2_q;
    rdata_d  = rd_v2_q ? i_mem_rdata : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      burst_cnt_q <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_v1_q     <= 1'b0;
      rd_v2_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      run_q       <= run_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      burst_cnt_q <= burst_cnt_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_v1_q     <= rd_v1_d;
      rd_v2_q     <= rd_v2_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {i_waddr, i_wdata};
  end

`ifdef FRAME_MEM_ARB_STAT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (i_wreq && !o_wready && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign o_wstall_cnt = stall_cnt_q;
`else
  assign o_wstall_cnt = '0;
`endif

  assign o_mem_cs      = mem_cs_q;
  assign o_mem_we      = mem_we_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_wdata   = mem_wdata_q;
  assign o_rvalid      = rvalid_q;
  assign o_rdata       = rdata_q;
  assign o_wfifo_level = level_q;

endmodule

// File: tb/tb_frame_memory_arbiter.sv
// -----------------------------------------------------------------------------
// Directed bench for frame_memory_arbiter. A behavioural single-port SRAM
// (1024 words are enough for the addresses used) sits on the o_mem_* side.
// Inputs change and outputs are sampled on the falling clock edge, so each
// "@(negedge clk)" crosses exactly one active rising edge.
// -----------------------------------------------------------------------------
module tb_frame_memory_arbiter;

  localparam int DW = 96;
  localparam int AW = 16;
  localparam int FD = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_wreq;
  logic          o_wready;
  logic [AW-1:0] i_waddr;
  logic [DW-1:0] i_wdata;
  logic          i_rreq;
  logic          o_rready;
  logic [AW-1:0] i_raddr;
  logic          o_rvalid;
  logic [DW-1:0] o_rdata;
  logic          o_mem_cs;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;
  logic [LW-1:0] o_wfifo_level;
  logic [31:0]   o_wstall_cnt;

  int n_vec = 0;
  int n_err = 0;

  frame_memory_arbiter #(
    .DATA_WIDTH(DW), .ADDR_DEPTH(65536), .ADDR_WIDTH(AW),
    .WFIFO_DEPTH(FD), .MAX_RD_BURST(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wreq(i_wreq), .o_wready(o_wready), .i_waddr(i_waddr), .i_wdata(i_wdata),
    .i_rreq(i_rreq), .o_rready(o_rready), .i_raddr(i_raddr),
    .o_rvalid(o_rvalid), .o_rdata(o_rdata),
    .o_mem_cs(o_mem_cs), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .o_wfifo_level(o_wfifo_level), .o_wstall_cnt(o_wstall_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  logic [DW-1:0] sram [0:1023];
  logic [DW-1:0] sram_rdata = '0;
  assign i_mem_rdata = sram_rdata;

  always @(posedge clk) begin
    if (o_mem_cs) begin
      if (o_mem_we) sram[o_mem_addr[9:0]] <= o_mem_wdata;
      else          sram_rdata <= sram[o_mem_addr[9:0]];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    i_wreq  = 1'b0;
    i_waddr = '0;
    i_wdata = '0;
    i_rreq  = 1'b0;
    i_raddr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_vec++; if (o_wready !== 1'b0) begin n_err++; $display("FAIL reset_wready: got %b want 0", o_wready); end
    n_vec++; if (o_rready !== 1'b0) begin n_err++; $display("FAIL reset_rready: got %b want 0", o_rready); end
    n_vec++; if ({o_rvalid, o_mem_cs, o_mem_we} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {o_rvalid, o_mem_cs, o_mem_we}); end
    n_vec++; if (o_mem_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", o_mem_addr); end
    n_vec++; if (o_mem_wdata !== '0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", o_mem_wdata); end
    n_vec++; if (o_rdata !== '0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", o_rdata); end
    n_vec++; if (o_wfifo_level !== '0) begin n_err++; $display("FAIL reset_level: got %0d want 0", o_wfifo_level); end
    n_vec++; if (o_wstall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", o_wstall_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (o_wready !== 1'b1) begin n_err++; $display("FAIL post_reset_wready: got %b want 1", o_wready); end
    n_vec++; if (o_rready !== 1'b1) begin n_err++; $display("FAIL post_reset_rready: got %b want 1", o_rready); end
  endtask

  task automatic test_reset_mid_read();
    i_rreq  = 1'b1;
    i_raddr = 16'h0005;
    @(negedge clk);
    n_vec++; if ({o_mem_cs, o_mem_we} !== 2'b10) begin n_err++; $display("FAIL midrd_issue: got %b want 10", {o_mem_cs, o_mem_we}); end
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if ({o_rvalid, o_mem_cs, o_mem_we, o_wready, o_rready} !== 5'b0) begin n_err++; $display("FAIL midrd_reset_flags: got %b want 00000", {o_rvalid, o_mem_cs, o_mem_we, o_wready, o_rready}); end
    n_vec++; if ({o_mem_addr, o_rdata, o_wfifo_level} !== '0) begin n_err++; $display("FAIL midrd_reset_values: got addr %h rdata %h level %0d want 0", o_mem_addr, o_rdata, o_wfifo_level); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (o_rvalid !== 1'b0) begin n_err++; $display("FAIL midrd_no_rvalid[%0d]: got %b want 0", i, o_rvalid); end
    end
  endtask

  task automatic test_idle_write();
    logic [DW-1:0] d;
    d = {12{8'hA5}};
    i_wreq  = 1'b1;
    i_waddr = 16'h0010;
    i_wdata = d;
    @(negedge clk);
    idle_inputs();
    n_vec++; if (o_wfifo_level !== 3'd1) begin n_err++; $display("FAIL wr_level_after_push: got %0d want 1", o_wfifo_level); end
    n_vec++; if (o_mem_cs !== 1'b0) begin n_err++; $display("FAIL wr_not_yet_issued: got %b want 0", o_mem_cs); end
    @(negedge clk);
    n_vec++; if ({o_mem_cs, o_mem_we} !== 2'b11) begin n_err++; $display("FAIL wr_issue: got %b want 11", {o_mem_cs, o_mem_we}); end
    n_vec++; if (o_mem_addr !== 16'h0010) begin n_err++; $display("FAIL wr_addr: got %h want 0010", o_mem_addr); end
    n_vec++; if (o_mem_wdata !== d) begin n_err++; $display("FAIL wr_data: got %h want %h", o_mem_wdata, d); end
    n_vec++; if (o_wfifo_level !== 3'd0) begin n_err++; $display("FAIL wr_level_drained: got %0d want 0", o_wfifo_level); end
    @(negedge clk);
    n_vec++; if (o_mem_cs !== 1'b0) begin n_err++; $display("FAIL wr_cs_drop: got %b want 0", o_mem_cs); end
    n_vec++; if (sram[16'h0010] !== d) begin n_err++; $display("FAIL wr_sram_content: got %h want %h", sram[16'h0010], d); end
  endtask

  task automatic test_read_latency();
    sram[16'h0020] = 96'h1234;
    n_vec++; if (o_rready !== 1'b1) begin n_err++; $display("FAIL rd_ready: got %b want 1", o_rready); end
    i_rreq  = 1'b1;
    i_raddr = 16'h0020;
    @(negedge clk);
    idle_inputs();
    n_vec++; if ({o_mem_cs, o_mem_we, o_mem_addr} !== {2'b10, 16'h0020}) begin n_err++; $display("FAIL rd_issue: got cs/we %b addr %h want 10 0020", {o_mem_cs, o_mem_we}, o_mem_addr); end
    n_vec++; if (o_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_valid_k1: got %b want 0", o_rvalid); end
    @(negedge clk);
    n_vec++; if (o_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_valid_k2: got %b want 0", o_rvalid); end
    @(negedge clk);
    n_vec++; if (o_rvalid !== 1'b1) begin n_err++; $display("FAIL rd_valid_k3: got %b want 1", o_rvalid); end
    n_vec++; if (o_rdata !== 96'h1234) begin n_err++; $display("FAIL rd_data: got %h want 1234", o_rdata); end
    @(negedge clk);
    n_vec++; if (o_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_valid_pulse: got %b want 0", o_rvalid); end
    n_vec++; if (o_rdata !== 96'h1234) begin n_err++; $display("FAIL rd_data_hold: got %h want 1234", o_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] e;
    for (int i = 0; i < 3; i++) sram[16'h0060 + i] = 96'hB000 + DW'(i * 17);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(96'hB000 + DW'(i * 17));
      i_rreq  = 1'b1;
      i_raddr = 16'h0060 + AW'(i);
      @(negedge clk);
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      n_vec++; if ({o_rvalid, o_rdata} !== {1'b1, e}) begin n_err++; $display("FAIL b2b_rd[%0d]: got v=%b %h want v=1 %h", i, o_rvalid, o_rdata, e); end
      @(negedge clk);
    end
    n_vec++; if (o_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b want 0", o_rvalid); end
  endtask

  task automatic test_starvation();
    logic exp_rdy;
    for (int j = 0; j < 19; j++) begin
      exp_rdy = !((j == 8) || (j == 17));
      n_vec++; if (o_rready !== exp_rdy) begin n_err++; $display("FAIL starve_rready[%0d]: got %b want %b", j, o_rready, exp_rdy); end
      i_rreq  = 1'b1;
      i_raddr = 16'h0040;
      i_wreq  = (j < 2);
      i_waddr = 16'h0050 + AW'(j);
      i_wdata = 96'hC0DE_0000 + DW'(j);
      @(negedge clk);
      if (j == 8) begin
        n_vec++; if ({o_mem_cs, o_mem_we, o_mem_addr} !== {2'b11, 16'h0050}) begin n_err++; $display("FAIL starve_wr0: got cs/we %b addr %h want 11 0050", {o_mem_cs, o_mem_we}, o_mem_addr); end
      end
      if (j == 17) begin
        n_vec++; if ({o_mem_cs, o_mem_we, o_mem_addr} !== {2'b11, 16'h0051}) begin n_err++; $display("FAIL starve_wr1: got cs/we %b addr %h want 11 0051", {o_mem_cs, o_mem_we}, o_mem_addr); end
      end
    end
    idle_inputs();
    repeat (3) @(negedge clk);
    n_vec++; if (o_wfifo_level !== 3'd0) begin n_err++; $display("FAIL starve_level: got %0d want 0", o_wfifo_level); end
    n_vec++; if (sram[16'h0051] !== 96'hC0DE_0001) begin n_err++; $display("FAIL starve_sram: got %h want c0de0001", sram[16'h0051]); end
  endtask

  task automatic test_fifo_full();
    logic          exp_rdy;
    logic [31:0]   exp_stall;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] e;
    for (int j = 0; j < 7; j++) begin
      exp_rdy = (j < 4);
      n_vec++; if (o_wready !== exp_rdy) begin n_err++; $display("FAIL full_wready[%0d]: got %b want %b", j, o_wready, exp_rdy); end
      if (j < 4) exp_q.push_back(96'hF000 + DW'(j));
      i_rreq  = 1'b1;
      i_raddr = 16'h0040;
      i_wreq  = 1'b1;
      i_waddr = 16'h0070 + AW'((j < 4) ? j : 4);
      i_wdata = 96'hF000 + DW'((j < 4) ? j : 4);
      @(negedge clk);
    end
    idle_inputs();
`ifdef FRAME_MEM_ARB_STAT_EN
    exp_stall = 32'd3;
`else
    exp_stall = 32'd0;
`endif
    n_vec++; if (o_wfifo_level !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d want 4", o_wfifo_level); end
    n_vec++; if (o_wstall_cnt !== exp_stall) begin n_err++; $display("FAIL full_stall_cnt: got %0d want %0d", o_wstall_cnt, exp_stall); end
    repeat (6) @(negedge clk);
    n_vec++; if (o_wfifo_level !== 3'd0) begin n_err++; $display("FAIL full_drained: got %0d want 0", o_wfifo_level); end
    for (int j = 0; j < 4; j++) begin
      e = exp_q.pop_front();
      n_vec++; if (sram[16'h0070 + j] !== e) begin n_err++; $display("FAIL full_sram[%0d]: got %h want %h", j, sram[16'h0070 + j], e); end
    end
    n_vec++; if (sram[16'h0074] !== '0) begin n_err++; $display("FAIL full_refused: got %h want 0", sram[16'h0074]); end
    n_vec++; if (o_wstall_cnt !== exp_stall) begin n_err++; $display("FAIL full_stall_hold: got %0d want %0d", o_wstall_cnt, exp_stall); end
  endtask

  task automatic test_no_forwarding();
    sram[16'h0030] = 96'hDEAD;
    i_wreq  = 1'b1;
    i_waddr = 16'h0030;
    i_wdata = 96'hBEEF;
    i_rreq  = 1'b1;
    i_raddr = 16'h0030;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    n_vec++; if ({o_mem_cs, o_mem_we} !== 2'b11) begin n_err++; $display("FAIL nofwd_wr_issue: got %b want 11", {o_mem_cs, o_mem_we}); end
    @(negedge clk);
    n_vec++; if ({o_rvalid, o_rdata} !== {1'b1, 96'hDEAD}) begin n_err++; $display("FAIL nofwd_old: got v=%b %h want v=1 dead", o_rvalid, o_rdata); end
    i_rreq  = 1'b1;
    i_raddr = 16'h0030;
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    n_vec++; if ({o_rvalid, o_rdata} !== {1'b1, 96'hBEEF}) begin n_err++; $display("FAIL nofwd_new: got v=%b %h want v=1 beef", o_rvalid, o_rdata); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = '0;
    test_reset();
    test_reset_mid_read();
    test_idle_write();
    test_read_latency();
    test_back_to_back();
    test_starvation();
    test_fifo_full();
    test_no_forwarding();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
